// File: rtl/jts16_bank_ctrl.sv
// rtl/jts16_bank_ctrl.sv - SDR SDRAM four-port bank responder for the JTS16 core
module jts16_bank_ctrl #(
    parameter int INIT_CYCLES = 10000,
    parameter int TRCD        = 2,
    parameter int TRP         = 2,
    parameter int TRFC        = 7,
    parameter int TWR         = 2,
    parameter int REF_PERIOD  = 780
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [21:0] ba0_addr,
    input  logic [21:0] ba1_addr,
    input  logic [21:0] ba2_addr,
    input  logic [21:0] ba3_addr,
    input  logic        ba0_rd,
    input  logic        ba1_rd,
    input  logic        ba2_rd,
    input  logic        ba3_rd,
    input  logic        ba0_wr,
    input  logic [15:0] ba0_din,
    input  logic [1:0]  ba0_din_m,
    output logic        ba0_ack,
    output logic        ba1_ack,
    output logic        ba2_ack,
    output logic        ba3_ack,
    output logic        ba0_rdy,
    output logic        ba1_rdy,
    output logic        ba2_rdy,
    output logic        ba3_rdy,
    output logic [31:0] data_read,
    input  logic        refresh_en,
    output logic        init_done,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_a,
    output logic [1:0]  sdram_dqm,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe,
    input  logic [15:0] sdram_dq_in
);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    localparam logic [15:0] C_INIT  = 16'(INIT_CYCLES - 1);
    localparam logic [15:0] C_TRCD  = 16'(TRCD - 1);
    localparam logic [15:0] C_TRP   = 16'(TRP - 1);
    localparam logic [15:0] C_TRFC  = 16'(TRFC - 1);
    localparam logic [15:0] C_WRDY  = 16'(TWR - 2);
    localparam logic [15:0] C_WEND  = 16'(TWR + TRP - 3);
    localparam logic [15:0] C_RLAST = 16'(REF_PERIOD - 1);

    typedef enum logic [3:0] {
        S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
        S_IDLE, S_ACT, S_RW, S_WAIT, S_REFRESH
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [1:0]  r_rr, w_rr_nxt;
    logic [1:0]  r_port, w_port_nxt;
    logic        r_wr, w_wr_nxt;
    logic [21:0] r_addr, w_addr_nxt;
    logic [15:0] r_din, w_din_nxt;
    logic [1:0]  r_dm, w_dm_nxt;
    logic [15:0] r_lo, w_lo_nxt;
    logic [3:0]  r_cmd, w_cmd_nxt;
    logic [1:0]  r_ba, w_ba_nxt;
    logic [12:0] r_a, w_a_nxt;
    logic [1:0]  r_dqm, w_dqm_nxt;
    logic [15:0] r_dq_out, w_dq_out_nxt;
    logic        r_dq_oe, w_dq_oe_nxt;
    logic [3:0]  r_ack, w_ack_nxt;
    logic [3:0]  r_rdy, w_rdy_nxt;
    logic [31:0] r_data, w_data_nxt;
    logic        r_init_done, w_init_done_nxt;
    logic [15:0] r_ref_cnt;
    logic        r_ref_pend;
    logic        w_ref_clr;

    logic [3:0]  w_req;
    logic        w_gnt_vld;
    logic [1:0]  w_gnt, w_idx;
    logic [21:0] w_gnt_addr;

    assign w_req = {ba3_rd, ba2_rd, ba1_rd, ba0_rd | ba0_wr};

    // Walk downward so the last hit is the first port at or after the RR pointer
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = r_rr;
        w_idx     = r_rr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_rr + 2'(k);
            if (w_req[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_idx;
            end
        end
    end

    always_comb begin
        w_gnt_addr = ba0_addr;
        case (w_gnt)
            2'd1:    w_gnt_addr = ba1_addr;
            2'd2:    w_gnt_addr = ba2_addr;
            2'd3:    w_gnt_addr = ba3_addr;
            default: w_gnt_addr = ba0_addr;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + 16'd1;
        w_rr_nxt        = r_rr;
        w_port_nxt      = r_port;
        w_wr_nxt        = r_wr;
        w_addr_nxt      = r_addr;
        w_din_nxt       = r_din;
        w_dm_nxt        = r_dm;
        w_lo_nxt        = r_lo;
        w_cmd_nxt       = CMD_NOP;
        w_ba_nxt        = r_ba;
        w_a_nxt         = r_a;
        w_dqm_nxt       = r_dqm;
        w_dq_out_nxt    = r_dq_out;
        w_dq_oe_nxt     = 1'b0;
        w_ack_nxt       = 4'd0;
        w_rdy_nxt       = 4'd0;
        w_data_nxt      = r_data;
        w_init_done_nxt = r_init_done;
        w_ref_clr       = 1'b0;
        case (r_state)
            S_INIT_WAIT: if (r_cnt == C_INIT) begin
                w_state_nxt = S_INIT_PRE;
                w_cnt_nxt   = '0;
                w_cmd_nxt   = CMD_PRE;
                w_a_nxt     = 13'h0400;
            end
            S_INIT_PRE: if (r_cnt == C_TRP) begin
                w_state_nxt = S_INIT_REF1;
                w_cnt_nxt   = '0;
                w_cmd_nxt   = CMD_REF;
            end
            S_INIT_REF1: if (r_cnt == C_TRFC) begin
                w_state_nxt = S_INIT_REF2;
                w_cnt_nxt   = '0;
                w_cmd_nxt   = CMD_REF;
            end
            S_INIT_REF2: if (r_cnt == C_TRFC) begin
                w_state_nxt = S_INIT_MRS;
                w_cnt_nxt   = '0;
                w_cmd_nxt   = CMD_MRS;
                w_a_nxt     = 13'h0021;
            end
            S_INIT_MRS: if (r_cnt == 16'd1) begin
                w_state_nxt     = S_IDLE;
                w_init_done_nxt = 1'b1;
            end
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (r_ref_pend && refresh_en) begin
                    w_state_nxt = S_REFRESH;
                    w_cmd_nxt   = CMD_REF;
                    w_ref_clr   = 1'b1;
                end else if (w_gnt_vld) begin
                    w_state_nxt = S_ACT;
                    w_cmd_nxt   = CMD_ACT;
                    w_ba_nxt    = w_gnt;
                    w_a_nxt     = w_gnt_addr[21:9];
                    w_port_nxt  = w_gnt;
                    w_wr_nxt    = (w_gnt == 2'd0) && ba0_wr;
                    w_addr_nxt  = w_gnt_addr;
                    w_din_nxt   = ba0_din;
                    w_dm_nxt    = ba0_din_m;
                    w_rr_nxt    = w_gnt + 2'd1;
                end
            end
            S_ACT: if (r_cnt == C_TRCD) begin
                w_state_nxt       = S_RW;
                w_cnt_nxt         = '0;
                w_a_nxt           = {2'b00, 1'b1, 1'b0, r_addr[8:0]};
                w_ack_nxt[r_port] = 1'b1;
                if (r_wr) begin
                    w_cmd_nxt    = CMD_WR;
                    w_dq_out_nxt = r_din;
                    w_dq_oe_nxt  = 1'b1;
                    w_dqm_nxt    = r_dm;
                end else begin
                    w_cmd_nxt    = CMD_RD;
                    w_dqm_nxt    = 2'b00;
                end
            end
            S_RW: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = '0;
                if (r_wr) w_dqm_nxt = 2'b11;
            end
            S_WAIT: begin
                if (r_wr) begin
                    if (r_cnt == C_WRDY) w_rdy_nxt[0] = 1'b1;
                    if (r_cnt == C_WEND) w_state_nxt = S_IDLE;
                end else begin
                    // CAS latency 2, burst 2: beats land on the two cycles after RW+1
                    if (r_cnt == 16'd1) w_lo_nxt = sdram_dq_in;
                    if (r_cnt == 16'd2) begin
                        w_state_nxt       = S_IDLE;
                        w_data_nxt        = {sdram_dq_in, r_lo};
                        w_rdy_nxt[r_port] = 1'b1;
                    end
                end
            end
            S_REFRESH: if (r_cnt == C_TRFC) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_INIT_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_INIT_WAIT;
            r_cnt       <= '0;
            r_rr        <= '0;
            r_port      <= '0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_din       <= '0;
            r_dm        <= '0;
            r_lo        <= '0;
            r_cmd       <= CMD_NOP;
            r_ba        <= '0;
            r_a         <= '0;
            r_dqm       <= 2'b11;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_ack       <= '0;
            r_rdy       <= '0;
            r_data      <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rr        <= w_rr_nxt;
            r_port      <= w_port_nxt;
            r_wr        <= w_wr_nxt;
            r_addr      <= w_addr_nxt;
            r_din       <= w_din_nxt;
            r_dm        <= w_dm_nxt;
            r_lo        <= w_lo_nxt;
            r_cmd       <= w_cmd_nxt;
            r_ba        <= w_ba_nxt;
            r_a         <= w_a_nxt;
            r_dqm       <= w_dqm_nxt;
            r_dq_out    <= w_dq_out_nxt;
            r_dq_oe     <= w_dq_oe_nxt;
            r_ack       <= w_ack_nxt;
            r_rdy       <= w_rdy_nxt;
            r_data      <= w_data_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    // A wrap while a refresh is still owed does not queue a second one
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ref_cnt  <= '0;
            r_ref_pend <= 1'b0;
        end else if (r_ref_cnt == C_RLAST) begin
            r_ref_cnt  <= '0;
            r_ref_pend <= 1'b1;
        end else begin
            r_ref_cnt  <= r_ref_cnt + 16'd1;
            if (w_ref_clr) r_ref_pend <= 1'b0;
        end
    end

    assign {ba3_ack, ba2_ack, ba1_ack, ba0_ack} = r_ack;
    assign {ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy} = r_rdy;
    assign data_read    = r_data;
    assign init_done    = r_init_done;
    assign sdram_cmd    = r_cmd;
    assign sdram_ba     = r_ba;
    assign sdram_a      = r_a;
    assign sdram_dqm    = r_dqm;
    assign sdram_dq_out = r_dq_out;
    assign sdram_dq_oe  = r_dq_oe;

endmodule

// File: tb/tb_jts16_bank_ctrl.sv
// tb/tb_jts16_bank_ctrl.sv - directed vector bench for jts16_bank_ctrl
module tb_jts16_bank_ctrl;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;

    logic        clk;
    logic        rstn;
    logic [21:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
    logic        ba0_rd, ba1_rd, ba2_rd, ba3_rd, ba0_wr;
    logic [15:0] ba0_din;
    logic [1:0]  ba0_din_m;
    logic        ba0_ack, ba1_ack, ba2_ack, ba3_ack;
    logic        ba0_rdy, ba1_rdy, ba2_rdy, ba3_rdy;
    logic [31:0] data_read;
    logic        refresh_en;
    logic        init_done;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_a;
    logic [1:0]  sdram_dqm;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;
    logic [15:0] sdram_dq_in = 16'hDEAD;

    logic [3:0]  w_acks, w_rdys;
    assign w_acks = {ba3_ack, ba2_ack, ba1_ack, ba0_ack};
    assign w_rdys = {ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy};

    jts16_bank_ctrl #(
        .INIT_CYCLES(20), .TRCD(2), .TRP(2), .TRFC(7), .TWR(2), .REF_PERIOD(100)
    ) dut (
        .clk(clk), .rstn(rstn),
        .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
        .ba0_rd(ba0_rd), .ba1_rd(ba1_rd), .ba2_rd(ba2_rd), .ba3_rd(ba3_rd),
        .ba0_wr(ba0_wr), .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
        .ba0_ack(ba0_ack), .ba1_ack(ba1_ack), .ba2_ack(ba2_ack), .ba3_ack(ba3_ack),
        .ba0_rdy(ba0_rdy), .ba1_rdy(ba1_rdy), .ba2_rdy(ba2_rdy), .ba3_rdy(ba3_rdy),
        .data_read(data_read), .refresh_en(refresh_en), .init_done(init_done),
        .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_a(sdram_a),
        .sdram_dqm(sdram_dqm), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
        .sdram_dq_in(sdram_dq_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // SDRAM model and bus monitor, all sampled mid-cycle
    logic [15:0] model_lo = 16'h0000;
    logic [15:0] model_hi = 16'h0000;
    logic [15:0] mem_word = 16'h0000;
    int rd_age    = 10;
    int ack_total = 0;
    int rdy_total = 0;
    int rw_total  = 0;
    int ref_total = 0;
    int ack_pre   = 0;
    int multi     = 0;
    int ack_q[$];
    int act_q[$];

    always @(negedge clk) begin
        if (sdram_cmd == C_RD) rd_age = 0;
        else if (rd_age < 10) rd_age++;
        sdram_dq_in = (rd_age == 2) ? model_lo : (rd_age == 3) ? model_hi : 16'hDEAD;
        if (rstn) begin
            if (!$onehot0(w_acks) || !$onehot0(w_rdys)) multi++;
            for (int k = 0; k < 4; k++) begin
                if (w_acks[k]) begin
                    ack_q.push_back(k);
                    ack_total++;
                    if (!init_done) ack_pre++;
                end
            end
            if (w_rdys != 4'd0) rdy_total++;
            if (sdram_cmd == C_ACT) act_q.push_back(int'(sdram_ba));
            if (sdram_cmd == C_RD || sdram_cmd == C_WR) rw_total++;
            if (sdram_cmd == C_REF) ref_total++;
            if (sdram_cmd == C_WR && sdram_dq_oe)
                mem_word = {sdram_dqm[1] ? mem_word[15:8] : sdram_dq_out[15:8],
                            sdram_dqm[0] ? mem_word[7:0]  : sdram_dq_out[7:0]};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cmd(output logic [3:0] c, output int gap);
        int i;
        c = C_NOP;
        gap = -1;
        i = 0;
        while (gap < 0 && i < 200) begin
            @(negedge clk);
            i++;
            if (sdram_cmd != C_NOP) begin
                c = sdram_cmd;
                gap = i;
            end
        end
    endtask

    task automatic set_rd(input int p, input logic v);
        case (p)
            0: ba0_rd = v;
            1: ba1_rd = v;
            2: ba2_rd = v;
            default: ba3_rd = v;
        endcase
    endtask

    task automatic set_addr(input int p, input logic [21:0] a);
        case (p)
            0: ba0_addr = a;
            1: ba1_addr = a;
            2: ba2_addr = a;
            default: ba3_addr = a;
        endcase
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pins"}, 32'({sdram_cmd, sdram_ba, sdram_a, sdram_dqm, sdram_dq_oe}),
              32'({C_NOP, 2'b00, 13'h0000, 2'b11, 1'b0}));
        check({tag, "_dq_out"}, 32'(sdram_dq_out), 32'h0);
        check({tag, "_data"}, data_read, 32'h0);
        check({tag, "_flags"}, 32'({init_done, w_acks, w_rdys}), 32'h0);
    endtask

    typedef struct {
        logic [1:0]  port;
        logic [21:0] addr;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [12:0] row;
        logic [12:0] a_rw;
        logic [31:0] data;
    } rd_vec_t;

    rd_vec_t vecs[5];
    int rr_exp[5];

    initial begin
        logic [3:0] c;
        int g;
        int p;
        int rsnap;

        vecs[0] = '{2'd1, 22'h012345, 16'hAAAA, 16'h5555, 13'h0091, 13'h0545, 32'h5555AAAA};
        vecs[1] = '{2'd3, 22'h3FFFFF, 16'h1234, 16'h5678, 13'h1FFF, 13'h05FF, 32'h56781234};
        vecs[2] = '{2'd0, 22'h000000, 16'hFFFF, 16'h0001, 13'h0000, 13'h0400, 32'h0001FFFF};
        vecs[3] = '{2'd2, 22'h200200, 16'h0F0F, 16'hF0F0, 13'h1001, 13'h0400, 32'hF0F00F0F};
        vecs[4] = '{2'd2, 22'h0001FF, 16'hC3C3, 16'h3C3C, 13'h0000, 13'h05FF, 32'h3C3CC3C3};
        rr_exp  = '{0, 1, 2, 3, 0};

        rstn = 1'b0;
        ba0_addr = 22'h0; ba1_addr = 22'h0; ba2_addr = 22'h0; ba3_addr = 22'h0;
        ba0_rd = 1'b1; ba1_rd = 1'b1; ba2_rd = 1'b1; ba3_rd = 1'b1;
        ba0_wr = 1'b0; ba0_din = 16'h0; ba0_din_m = 2'b00; refresh_en = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rstn = 1'b1;

        // init sequence with every read request already high
        next_cmd(c, g);
        check("init_pre_cmd", 32'(c), 32'(C_PRE));
        check("init_pre_a10", 32'(sdram_a[10]), 32'h1);
        check("init_done_early", 32'(init_done), 32'h0);
        next_cmd(c, g);
        check("init_ref1_cmd", 32'(c), 32'(C_REF));
        check("init_ref1_gap", 32'(g), 32'd2);
        next_cmd(c, g);
        check("init_ref2_cmd", 32'(c), 32'(C_REF));
        check("init_ref2_gap", 32'(g), 32'd7);
        next_cmd(c, g);
        check("init_mrs_cmd", 32'(c), 32'(C_MRS));
        check("init_mrs_gap", 32'(g), 32'd7);
        check("init_mrs_a", 32'(sdram_a), 32'h021);
        @(negedge clk);
        check("init_done_mrs1", 32'(init_done), 32'h0);
        @(negedge clk);
        check("init_done_set", 32'(init_done), 32'h1);
        check("no_ack_before_init", 32'(ack_pre), 32'h0);

        // round robin with all four held
        for (int i = 0; i < 300 && ack_q.size() < 5; i++) @(negedge clk);
        ba0_rd = 1'b0; ba1_rd = 1'b0; ba2_rd = 1'b0; ba3_rd = 1'b0;
        check("rr_count", 32'(ack_q.size() >= 5), 32'h1);
        for (int i = 0; i < 5; i++) begin
            check("rr_ack_port", 32'((i < ack_q.size()) ? ack_q[i] : 99), 32'(rr_exp[i]));
            check("rr_act_ba", 32'((i < act_q.size()) ? act_q[i] : 99), 32'(rr_exp[i]));
        end
        repeat (30) @(negedge clk);
        check("rr_all_rdy", 32'(rdy_total), 32'(ack_total));

        // table-driven single reads
        for (int i = 0; i < 5; i++) begin
            p = int'(vecs[i].port);
            model_lo = vecs[i].lo;
            model_hi = vecs[i].hi;
            set_addr(p, vecs[i].addr);
            set_rd(p, 1'b1);
            next_cmd(c, g);
            check("rd_act_cmd", 32'(c), 32'(C_ACT));
            check("rd_act_ba", 32'(sdram_ba), 32'(vecs[i].port));
            check("rd_act_row", 32'(sdram_a), 32'(vecs[i].row));
            next_cmd(c, g);
            check("rd_cmd", 32'(c), 32'(C_RD));
            check("rd_trcd_gap", 32'(g), 32'd2);
            check("rd_a", 32'(sdram_a), 32'(vecs[i].a_rw));
            check("rd_dqm", 32'(sdram_dqm), 32'h0);
            check("rd_ack", 32'(w_acks), 32'(1 << p));
            set_rd(p, 1'b0);
            repeat (3) @(negedge clk);
            check("rd_rdy_early", 32'(w_rdys), 32'h0);
            @(negedge clk);
            check("rd_rdy", 32'(w_rdys), 32'(1 << p));
            check("rd_data", data_read, vecs[i].data);
            repeat (3) @(negedge clk);
            check("rd_data_hold", data_read, vecs[i].data);
        end

        // masked write with ba0_rd also high: write must win
        ba0_addr = 22'h000010; ba0_din = 16'hBEEF; ba0_din_m = 2'b10;
        ba0_wr = 1'b1; ba0_rd = 1'b1;
        next_cmd(c, g);
        check("wr_act_cmd", 32'(c), 32'(C_ACT));
        check("wr_act_ba", 32'(sdram_ba), 32'h0);
        next_cmd(c, g);
        check("wr_cmd", 32'(c), 32'(C_WR));
        check("wr_gap", 32'(g), 32'd2);
        check("wr_pins", 32'({sdram_dqm, sdram_dq_oe, sdram_dq_out}), 32'({2'b10, 1'b1, 16'hBEEF}));
        check("wr_a", 32'(sdram_a), 32'h410);
        check("wr_ack", 32'(w_acks), 32'h1);
        ba0_wr = 1'b0; ba0_rd = 1'b0;
        ba1_addr = 22'h000020; ba1_rd = 1'b1;
        @(negedge clk);
        check("wr_beat2", 32'({sdram_dqm, sdram_dq_oe}), 32'({2'b11, 1'b0}));
        check("wr_rdy_early", 32'(w_rdys), 32'h0);
        @(negedge clk);
        check("wr_rdy", 32'(w_rdys), 32'h1);
        next_cmd(c, g);
        check("wr_next_act_cmd", 32'(c), 32'(C_ACT));
        check("wr_next_act_spacing", 32'(g >= 2), 32'h1);
        check("wr_mem", 32'(mem_word), 32'h00EF);
        next_cmd(c, g);
        check("wr_next_rd", 32'(c), 32'(C_RD));
        ba1_rd = 1'b0;
        repeat (8) @(negedge clk);

        // refresh owed but not permitted: read goes first
        repeat (110) @(negedge clk);
        check("ref_none_yet", 32'(ref_total), 32'd2);
        model_lo = 16'h1111; model_hi = 16'h2222;
        ba2_addr = 22'h0ABCDE; ba2_rd = 1'b1;
        next_cmd(c, g);
        check("refoff_act", 32'({c, sdram_ba}), 32'({C_ACT, 2'd2}));
        next_cmd(c, g);
        check("refoff_rd", 32'(c), 32'(C_RD));
        ba2_rd = 1'b0;
        repeat (4) @(negedge clk);
        check("refoff_rdy", 32'(w_rdys), 32'h4);
        check("refoff_data", data_read, 32'h22221111);
        check("refoff_no_ref", 32'(ref_total), 32'd2);
        repeat (2) @(negedge clk);
        refresh_en = 1'b1;
        next_cmd(c, g);
        check("ref_cmd", 32'(c), 32'(C_REF));
        refresh_en = 1'b0;
        ba3_addr = 22'h000100; ba3_rd = 1'b1;
        next_cmd(c, g);
        check("ref_then_act", 32'({c, sdram_ba}), 32'({C_ACT, 2'd3}));
        check("ref_trfc_gap", 32'(g), 32'd8);
        next_cmd(c, g);
        ba3_rd = 1'b0;
        repeat (8) @(negedge clk);

        // reset during the WAIT phase of a read
        ba1_addr = 22'h012345; ba1_rd = 1'b1;
        next_cmd(c, g);
        next_cmd(c, g);
        check("abort_rd_cmd", 32'(c), 32'(C_RD));
        ba1_rd = 1'b0;
        repeat (2) @(negedge clk);
        rsnap = rdy_total;
        rstn = 1'b0;
        #1;
        check_reset_state("abort");
        @(negedge clk);
        rstn = 1'b1;
        next_cmd(c, g);
        check("abort_restart_pre", 32'(c), 32'(C_PRE));
        check("abort_no_rdy", 32'(rdy_total), 32'(rsnap));
        check("abort_init_done", 32'(init_done), 32'h0);

        check("one_hot_ack_rdy", 32'(multi), 32'h0);
        check("ack_per_cmd", 32'(ack_total), 32'(rw_total));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/jts16_bank_ctrl.md
# jts16_bank_ctrl

SDRAM bank responder for the JTS16 core: the controller side of the four-bank request interface that the game top drives. It accepts `ba*_rd`/`ba0_wr` requests, arbitrates them round-robin and sequences SDR SDRAM commands: init, ACTIVE, READ/WRITE with auto-precharge, and AUTO REFRESH. It returns `ba*_ack`, `ba*_rdy` and a 32-bit `data_read`. It sits between `jts16_game` and the SDRAM pins, one access in flight at a time.

## Interface
- `INIT_CYCLES`, default 10000: clocks to wait after reset before the first command.
- `TRCD`, default 2: ACTIVE to READ/WRITE, in clocks.
- `TRP`, default 2: PRECHARGE to next command, in clocks.
- `TRFC`, default 7: AUTO REFRESH to next command, in clocks.
- `TWR`, default 2: WRITE to `ba0_rdy`, in clocks.
- `REF_PERIOD`, default 780: clocks between refresh requests.
- `clk` in 1: system clock.
- `rstn` in 1: reset; asynchronous, active-low.
- `ba0_addr`, `ba1_addr`, `ba2_addr`, `ba3_addr` in 22 each: 16-bit word addresses. Row is `[21:9]`, column is `[8:0]`.
- `ba0_rd`, `ba1_rd`, `ba2_rd`, `ba3_rd` in 1 each: read requests, level, held until ack.
- `ba0_wr` in 1: write request for bank 0 only.
- `ba0_din` in 16: write data.
- `ba0_din_m` in 2: byte mask; 1 = byte not written.
- `ba0_ack` … `ba3_ack` out 1 each: command accepted, 1-cycle pulse.
- `ba0_rdy` … `ba3_rdy` out 1 each: access complete, 1-cycle pulse.
- `data_read` out 32: read data, `{second word, first word}`.
- `refresh_en` in 1: refresh permitted (high during blanking).
- `init_done` out 1: init sequence finished.
- `sdram_cmd` out 4: `{cs_n,ras_n,cas_n,we_n}`.
- `sdram_ba` out 2: SDRAM bank, equal to the request port index.
- `sdram_a` out 13: SDRAM address.
- `sdram_dqm` out 2: SDRAM data mask.
- `sdram_dq_out` out 16: write data to pins.
- `sdram_dq_oe` out 1: drive DQ.
- `sdram_dq_in` in 16: DQ sampled from pins.

## Operation
- Commands:
  - NOP `0111`
  - ACTIVE `0011`
  - READ `0101`
  - WRITE `0100`
  - PRECHARGE `0010`
  - AUTO REFRESH `0001`
  - LOAD MODE `0000`
- Reset values: `sdram_cmd`=NOP, `sdram_a`=0, `sdram_ba`=0, `sdram_dqm`=2'b11, `sdram_dq_oe`=0, `sdram_dq_out`=0, all ack/rdy=0, `data_read`=0, `init_done`=0. The refresh counter and RR pointer clear to 0.
- States: INIT_WAIT → INIT_PRE → INIT_REF1 → INIT_REF2 → INIT_MRS → IDLE; IDLE → ACT → RW → WAIT → IDLE; IDLE → REFRESH → IDLE.
- INIT sequence:
  - INIT_WAIT lasts `INIT_CYCLES`.
  - INIT_PRE: PRECHARGE with `a[10]`=1, then `TRP` wait.
  - INIT_REF1 and INIT_REF2: each issues AUTO REFRESH, then `TRFC` wait.
  - INIT_MRS: LOAD MODE with `a`=13'h021 (CL2, BL2, sequential), then 2-cycle wait.
  - `init_done` goes 1 on entering IDLE and stays 1 until reset.
- Requests are ignored until `init_done`.
- Refresh counter:
  - Counts 0..`REF_PERIOD`-1; at wrap it sets `ref_pend`.
  - A second wrap while `ref_pend` is still set does not accumulate a second refresh.
- IDLE priority:
  1. If `ref_pend` & `refresh_en`: AUTO REFRESH, wait `TRFC`, clear `ref_pend`.
  2. Otherwise grant a request. Search starts at the RR pointer and moves upward with wrap 3→0; the pointer becomes grant+1 mod 4.
- Bank 0 with both `ba0_rd` and `ba0_wr` high: the write wins.
- ACT: ACTIVE with `ba`=port, `a`=row.
- RW: issued `TRCD` clocks after ACTIVE.
  - `a`=`{2'b00, 1'b1, 1'b0, col}`; `a[10]`=1 selects auto-precharge.
  - Read: READ with `dqm`=00.
  - Write: WRITE with `dq_out`=`ba0_din`, `dq_oe`=1, `dqm`=`ba0_din_m`. The next cycle drives `dqm`=11 to mask the second burst beat, and `dq_oe` returns to 0.
- Ack: the port's ack pulses in the RW cycle. The requester may drop rd/wr on the following cycle.
- Completion is covered in Timing.
- Reset mid-access: everything returns to INIT_WAIT with reset values; no ack/rdy are produced for the aborted access.

## Timing
- ACTIVE at cycle T; READ/WRITE at T+`TRCD`.
- Read:
  - `sdram_dq_in` sampled at READ+2 (low word) and READ+3 (high word).
  - `data_read` and `rdy` registered at READ+4.
  - IDLE is re-entered at READ+4.
  - The next ACTIVE is allowed at READ+5 or later; this satisfies auto-precharge `TRP`.
- Write: `ba0_rdy` at WRITE+`TWR`; IDLE follows and the next ACTIVE is at least WRITE+`TWR`+`TRP`.
- Minimum request-to-data for a read, grant taken in the IDLE cycle: ACTIVE+`TRCD`+4 = 6 clocks with defaults.
- `data_read` holds its value until the next read completes.
- Each ack precedes its rdy; at most one ack and one rdy are high in any cycle.

## Test plan
- Init, `INIT_CYCLES`=20: commands are PRECHARGE (`a[10]`=1), 2× AUTO REFRESH spaced 7 clocks, then LOAD MODE `a`=021; `init_done`=1 after that; no acks before.
- `ba1_rd` with `ba1_addr`=22'h12345: ACTIVE `ba`=1, `a`=row 13'h091. READ 2 cycles later with column 9'h145 and `a[10]`=1. Model returns 16'hAAAA then 16'h5555, giving `data_read`=32'h5555AAAA with `ba1_rdy` at READ+4.
- `ba0_wr` with `din`=16'hBEEF and mask 2'b10: WRITE with `dqm`=10 and `dq_oe`=1 for one cycle, `dqm`=11 the next cycle. `ba0_ack` then `ba0_rdy` 2 clocks later; the model stores only the low byte EF.
- All four rd held high from reset: grants come in order 0,1,2,3,0; each ack exactly once per transaction.
- `ref_pend` set while `refresh_en`=0 and `ba2_rd` pending: read is served, no refresh. Raise `refresh_en` with no pending requests: AUTO REFRESH, then 7 idle clocks before the next ACTIVE.
- `rstn` pulsed low during WAIT of a read: no `rdy`, outputs at reset values, init restarts.
